// File: rtl/rotated_sprite_buffer.sv
// -----------------------------------------------------------------------------
// rotated_sprite_buffer
//
// Downstream stage of the image rotator. Holds the rotator's scan-enable level
// high while capturing, stores one raster-ordered IMAGE_SIZE x IMAGE_SIZE
// rotated sprite into the back bank of a ping-pong buffer, and swaps banks once
// the last pixel lands. The compositor reads the front bank at random with a
// one-cycle registered latency; capture into the back bank never disturbs it.
//
// Ports
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_start              pulse: request capture of a new sprite (IDLE only)
//   o_rot_start          level to rotator start; high while capturing
//   i_valid              one pixel beat per high cycle
//   i_pixel, i_opacity   beat payload
//   i_rd_H, i_rd_V       read column / row
//   o_rd_pixel           registered read pixel (0 while not ready)
//   o_rd_opacity         registered read opacity (0 while not ready)
//   o_ready              front bank holds a complete sprite
//   o_busy               capture in progress
//   o_done               one-cycle pulse on bank swap
//   o_err                sticky: idle timeout or stray beat; cleared by start
// -----------------------------------------------------------------------------
module rotated_sprite_buffer #(
  parameter int IMAGE_SIZE  = 32,
  parameter int COOR_WIDTH  = 5,
  parameter int COLOR_WIDTH = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  output logic                   o_rot_start,
  input  logic                   i_valid,
  input  logic [COLOR_WIDTH-1:0] i_pixel,
  input  logic                   i_opacity,
  input  logic [COOR_WIDTH-1:0]  i_rd_H,
  input  logic [COOR_WIDTH-1:0]  i_rd_V,
  output logic [COLOR_WIDTH-1:0] o_rd_pixel,
  output logic                   o_rd_opacity,
  output logic                   o_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);

  localparam int ADDR_W = 2 * COOR_WIDTH + 1;
  localparam int DEPTH  = 2 * IMAGE_SIZE * IMAGE_SIZE;
  localparam int IDLE_W = $clog2(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_SWAP} state_t;

  state_t                 r_state, w_next;
  logic                   r_bank_sel;
  logic [COOR_WIDTH-1:0]  r_wr_H, r_wr_V;
  logic [IDLE_W-1:0]      r_idle_cnt;
  logic                   r_rot_start, r_busy, r_done, r_err, r_ready;
  logic [COLOR_WIDTH-1:0] r_rd_pixel;
  logic                   r_rd_opacity;
  logic [COLOR_WIDTH:0]   r_mem [DEPTH];

  logic                   w_last, w_timeout, w_wr_en;
  logic [ADDR_W-1:0]      w_wr_addr, w_rd_addr;

  // Bank index is the address MSB: capture targets the back bank, reads the front.
  assign w_wr_addr = {~r_bank_sel, r_wr_V, r_wr_H};
  assign w_rd_addr = { r_bank_sel, i_rd_V, i_rd_H};
  assign w_wr_en   = (r_state == S_FILL) && i_valid;
  assign w_last    = (&r_wr_H) && (&r_wr_V);
  assign w_timeout = !i_valid && (r_idle_cnt == IDLE_MAX);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, whatever the block order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_FILL;
      S_FILL: begin
        if (i_valid && w_last) w_next = S_SWAP;
        else if (w_timeout)    w_next = S_IDLE;
      end
      S_SWAP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bank_sel  <= 1'b0;
      r_wr_H      <= '0;
      r_wr_V      <= '0;
      r_idle_cnt  <= '0;
      r_rot_start <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_wr_H      <= '0;
            r_wr_V      <= '0;
            r_idle_cnt  <= '0;
            r_err       <= 1'b0;
            r_rot_start <= 1'b1;
            r_busy      <= 1'b1;
          end else if (i_valid) begin
            r_err <= 1'b1;
          end
        end
        S_FILL: begin
          if (i_valid) begin
            r_idle_cnt <= '0;
            r_wr_H     <= r_wr_H + 1'b1;
            if (&r_wr_H) r_wr_V <= r_wr_V + 1'b1;
            if (w_last)  r_rot_start <= 1'b0;
          end else if (w_timeout) begin
            // Abort: back bank is abandoned, front bank and o_ready untouched.
            r_err       <= 1'b1;
            r_rot_start <= 1'b0;
            r_busy      <= 1'b0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        S_SWAP: begin
          r_bank_sel <= ~r_bank_sel;
          r_ready    <= 1'b1;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          if (i_valid) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the sprite store has no reset; o_ready gates every read so stale
  // contents are never visible, and a resettable array would not map to RAM.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= {i_opacity, i_pixel};
  end

  // Registered read of the front bank as selected before this edge, so a read
  // sampled on the swap edge still returns the old sprite.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_pixel   <= '0;
      r_rd_opacity <= 1'b0;
    end else if (r_ready) begin
      {r_rd_opacity, r_rd_pixel} <= r_mem[w_rd_addr];
    end else begin
      r_rd_pixel   <= '0;
      r_rd_opacity <= 1'b0;
    end
  end

  assign o_rot_start  = r_rot_start;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_ready      = r_ready;
  assign o_rd_pixel   = r_rd_pixel;
  assign o_rd_opacity = r_rd_opacity;

endmodule

// File: tb/tb_rotated_sprite_buffer.sv
// -----------------------------------------------------------------------------
// tb_rotated_sprite_buffer
//
// Self-checking bench for rotated_sprite_buffer with a 4x4 sprite. A behavioural
// model (front/back sprite arrays, a beat counter and an idle counter) predicts
// every output after every clock; directed sequences and a read table cover
// the corner cases, and a randomized phase exercises mixed traffic.
// -----------------------------------------------------------------------------
module tb_rotated_sprite_buffer;

  localparam int IS   = 4;
  localparam int CW   = 2;
  localparam int COLW = 4;
  localparam int TO   = 64;
  localparam int N    = IS * IS;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start, valid, op;
  logic [COLW-1:0] pix;
  logic [CW-1:0]   rd_h, rd_v;
  logic [COLW-1:0] rd_pix;
  logic            rd_op, rot_start, ready, busy, done, err;

  rotated_sprite_buffer #(
    .IMAGE_SIZE(IS), .COOR_WIDTH(CW), .COLOR_WIDTH(COLW), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_rot_start(rot_start),
    .i_valid(valid), .i_pixel(pix), .i_opacity(op),
    .i_rd_H(rd_h), .i_rd_V(rd_v),
    .o_rd_pixel(rd_pix), .o_rd_opacity(rd_op),
    .o_ready(ready), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int done_seen = 0;

  always @(posedge clk) if (done) done_seen++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [COLW:0] m_front [N];
  logic [COLW:0] m_back  [N];
  bit m_ready = 0, m_fill = 0, m_swap = 0, m_err = 0;
  int m_cnt = 0, m_idle = 0;

  // One clock: predict, advance, compare every output.
  task automatic step();
    int            a;
    logic [COLW:0] exp_rd;
    bit            did_swap;
    a        = int'(rd_v) * IS + int'(rd_h);
    exp_rd   = m_ready ? m_front[a] : '0;
    did_swap = m_swap;
    if (did_swap) begin
      m_front = m_back;
      m_ready = 1;
      m_swap  = 0;
      if (valid) m_err = 1;
    end else if (m_fill) begin
      if (valid) begin
        m_back[m_cnt] = {op, pix};
        m_cnt++;
        m_idle = 0;
        if (m_cnt == N) begin m_fill = 0; m_swap = 1; end
      end else begin
        m_idle++;
        if (m_idle == TO) begin m_fill = 0; m_err = 1; end
      end
    end else if (start) begin
      m_fill = 1; m_cnt = 0; m_idle = 0; m_err = 0;
    end else if (valid) begin
      m_err = 1;
    end
    @(posedge clk); #1;
    check("rd_pixel",  rd_pix,    exp_rd[COLW-1:0]);
    check("rd_opac",   rd_op,     exp_rd[COLW]);
    check("done",      done,      did_swap);
    check("ready",     ready,     m_ready);
    check("busy",      busy,      m_fill || m_swap);
    check("rot_start", rot_start, m_fill);
    check("err",       err,       m_err);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_pixel"},  rd_pix,    0);
    check({tag, "_rd_opac"},   rd_op,     0);
    check({tag, "_ready"},     ready,     0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_rot_start"}, rot_start, 0);
    check({tag, "_err"},       err,       0);
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask

  function automatic logic [COLW:0] sprite_px(input int kind, input int idx);
    case (kind)
      0:       return {idx != 0, 4'(idx)};
      1:       return {1'b1, 4'd9};
      default: return 5'($urandom);
    endcase
  endfunction

  // Full capture; start_at >= 0 raises a stray i_start on that beat.
  task automatic capture(input int kind, input int gap, input int start_at,
                         output logic [COLW-1:0] rd_at_swap,
                         output logic [COLW-1:0] rd_after);
    pulse_start();
    check("cap_rot_start_up", rot_start, 1);
    check("cap_busy_up", busy, 1);
    for (int i = 0; i < N; i++) begin
      {op, pix} = sprite_px(kind, i);
      valid = 1;
      start = (i == start_at);
      step();
      valid = 0;
      start = 0;
      if (i != N - 1) repeat (gap) step();
    end
    check("cap_no_done_on_last_beat", done, 0);
    check("cap_rot_start_drop", rot_start, 0);
    step();
    rd_at_swap = rd_pix;
    check("cap_done_pulse", done, 1);
    check("cap_ready", ready, 1);
    check("cap_busy_clear", busy, 0);
    step();
    rd_after = rd_pix;
    check("cap_done_one_cycle", done, 0);
  endtask

  typedef struct {
    logic [CW-1:0]   h;
    logic [CW-1:0]   v;
    logic [COLW-1:0] pix;
    logic            op;
  } rd_vec_t;

  rd_vec_t vecs [6];

  task automatic read_table(input string tag);
    for (int i = 0; i < 6; i++) begin
      rd_h = vecs[i].h;
      rd_v = vecs[i].v;
      step();
      check({tag, "_pix"}, rd_pix, vecs[i].pix);
      check({tag, "_op"},  rd_op,  vecs[i].op);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [COLW-1:0] r0, r1;
    int d0;

    // Index sprite: pixel = V*4+H, opacity = (index != 0).
    vecs[0] = '{2'd2, 2'd1, 4'd6,  1'b1};
    vecs[1] = '{2'd0, 2'd0, 4'd0,  1'b0};
    vecs[2] = '{2'd3, 2'd3, 4'd15, 1'b1};
    vecs[3] = '{2'd1, 2'd0, 4'd1,  1'b1};
    vecs[4] = '{2'd0, 2'd3, 4'd12, 1'b1};
    vecs[5] = '{2'd3, 2'd0, 4'd3,  1'b1};

    rst_n = 0; start = 0; valid = 0; op = 0; pix = '0; rd_h = '0; rd_v = '0;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1;
    step();

    // Full back-to-back capture, then table reads.
    capture(0, 0, -1, r0, r1);
    read_table("full");

    // Gapped stream lands in the other bank with identical contents.
    capture(0, 3, -1, r0, r1);
    check("gap_no_err", err, 0);
    read_table("gapped");

    // Timeout after 5 beats: 63 idle cycles still fine, the 64th aborts.
    rd_h = 2'd2; rd_v = 2'd1;
    d0 = done_seen;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      {op, pix} = sprite_px(2, i);
      valid = 1; step(); valid = 0;
    end
    repeat (TO - 1) step();
    check("to_err_before", err, 0);
    check("to_busy_before", busy, 1);
    step();
    check("to_err", err, 1);
    check("to_busy", busy, 0);
    check("to_rot_start", rot_start, 0);
    check("to_ready_kept", ready, 1);
    check("to_rd_kept", rd_pix, 6);
    step();
    check("to_no_done", done_seen, d0);

    // Ping-pong isolation: read (0,0) every cycle while sprite of 9s arrives.
    rd_h = 2'd0; rd_v = 2'd0;
    capture(1, 0, -1, r0, r1);
    check("pp_read_on_swap_edge_old", r0, 0);
    check("pp_read_after_swap_new", r1, 9);

    // Stray beat in IDLE sets err; next start clears it.
    valid = 1; step(); valid = 0;
    check("stray_err", err, 1);
    step();
    check("stray_err_sticky", err, 1);
    pulse_start();
    check("start_clears_err", err, 0);
    // Abandon that capture via reset, then capture with a mid-fill start.
    for (int i = 0; i < 8; i++) begin
      {op, pix} = sprite_px(2, i);
      valid = 1; step(); valid = 0;
    end
    rst_n = 0;
    #1;
    check_all_zero("midreset");
    m_fill = 0; m_swap = 0; m_ready = 0; m_err = 0;
    @(posedge clk); #1;
    rst_n = 1;
    step();
    capture(0, 0, 5, r0, r1);
    check("mid_start_no_err", err, 0);
    read_table("after_reset");

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      rd_h  = 2'($urandom);
      rd_v  = 2'($urandom);
      start = ($urandom_range(0, 39) == 0);
      valid = m_fill ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 49) == 0);
      {op, pix} = 5'($urandom);
      step();
      start = 0;
      valid = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
